// File: rtl/aircon_pkg.sv
// Shared types and constants for the aircon relay actuator.
// AIRCON_FAULT_EN adds the sticky FAULT state.
package aircon_pkg;

    localparam int unsigned TIMER_W      = 8;
    localparam int unsigned FAN_LEAD_DEF = 2;
    localparam int unsigned FAN_TAIL_DEF = 3;
    localparam int unsigned MIN_OFF_DEF  = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FAN_PRE  = 3'd1,
        HEAT     = 3'd2,
        COOL     = 3'd3,
        FAN_POST = 3'd4
`ifdef AIRCON_FAULT_EN
        ,
        FAULT    = 3'd5
`endif
    } act_state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_HEAT = 2'd1,
        REQ_COOL = 2'd2
    } req_t;

    // Conflicting upstream requests collapse to no request.
    function automatic req_t decode_req(input logic heat, input logic cool);
        if (heat && !cool) return REQ_HEAT;
        if (cool && !heat) return REQ_COOL;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/aircon_if.sv
// Request/relay bundle between the aircon controller and the actuator.
// The fault flag exists only when AIRCON_FAULT_EN is defined.
interface aircon_if;

    logic heating_req;
    logic cooling_req;
    logic fan_on;
    logic heater_on;
    logic compressor_on;
    logic lockout;
`ifdef AIRCON_FAULT_EN
    logic fault;
`endif

    modport master (
        output heating_req, cooling_req,
        input  fan_on, heater_on, compressor_on, lockout
`ifdef AIRCON_FAULT_EN
        , fault
`endif
    );

    modport slave (
        input  heating_req, cooling_req,
        output fan_on, heater_on, compressor_on, lockout
`ifdef AIRCON_FAULT_EN
        , fault
`endif
    );

endinterface

// File: rtl/hold_timer.sv
// Loadable 8-bit down-counter that saturates at zero.
module hold_timer
    import aircon_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic [TIMER_W-1:0] value,
    output logic               zero_c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - TIMER_W'(1);
        end
    end

    assign zero_c = (value == '0);

endmodule

// File: rtl/aircon_actuator.sv
// Fan/heater/compressor relay sequencer with fan lead/tail and compressor min-off lockout.
// Define AIRCON_FAULT_EN to add the sticky fault on sustained conflicting requests.
module aircon_actuator
    import aircon_pkg::*;
#(
    parameter int unsigned FAN_LEAD = FAN_LEAD_DEF,
    parameter int unsigned FAN_TAIL = FAN_TAIL_DEF,
    parameter int unsigned MIN_OFF  = MIN_OFF_DEF
) (
    input  logic     clk,
    input  logic     rst,
    aircon_if.slave  bus
);

    act_state_t         state;
    act_state_t         state_next;
    req_t               req_c;

    logic               fsm_load;
    logic [TIMER_W-1:0] fsm_load_val;
    logic               fsm_dec;
    logic [TIMER_W-1:0] fsm_val;
    logic               fsm_zero_c;
    logic               fsm_expired_c;

    logic               lock_load_c;
    logic [TIMER_W-1:0] lock_val;
    logic               lock_zero_c;
    logic               lockout_next_c;

    logic               fan_q;
    logic               heater_q;
    logic               comp_q;
    logic               lockout_q;

    assign req_c = decode_req(bus.heating_req, bus.cooling_req);

    // A phase ends on the edge where the timer would step from 1 to 0.
    assign fsm_expired_c = fsm_zero_c || (fsm_val == TIMER_W'(1));

`ifdef AIRCON_FAULT_EN
    logic both_q;
    logic fault_q;
    logic fault_trip_c;

    assign fault_trip_c = bus.heating_req && bus.cooling_req && both_q;
`endif

    hold_timer u_fsm_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (fsm_load),
        .load_val (fsm_load_val),
        .dec      (fsm_dec),
        .value    (fsm_val),
        .zero_c   (fsm_zero_c)
    );

    // Min-off timer restarts whenever the compressor is about to drop.
    assign lock_load_c    = (state == COOL) && (state_next != COOL);
    assign lockout_next_c = lock_load_c ? (MIN_OFF != 0)
                                        : !(lock_zero_c || (lock_val == TIMER_W'(1)));

    hold_timer u_lock_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (lock_load_c),
        .load_val (TIMER_W'(MIN_OFF)),
        .dec      (1'b1),
        .value    (lock_val),
        .zero_c   (lock_zero_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        fsm_load     = 1'b0;
        fsm_load_val = '0;
        fsm_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (req_c != REQ_NONE) begin
                    state_next   = FAN_PRE;
                    fsm_load     = 1'b1;
                    fsm_load_val = TIMER_W'(FAN_LEAD);
                end
            end
            FAN_PRE: begin
                fsm_dec = 1'b1;
                if (req_c == REQ_NONE) begin
                    state_next   = FAN_POST;
                    fsm_load     = 1'b1;
                    fsm_load_val = TIMER_W'(FAN_TAIL);
                end else if (fsm_expired_c) begin
                    if (req_c == REQ_HEAT) begin
                        state_next = HEAT;
                    end else if (!lockout_q) begin
                        state_next = COOL;
                    end
                end
            end
            HEAT: begin
                if (req_c != REQ_HEAT) begin
                    state_next   = FAN_POST;
                    fsm_load     = 1'b1;
                    fsm_load_val = TIMER_W'(FAN_TAIL);
                end
            end
            COOL: begin
                if (req_c != REQ_COOL) begin
                    state_next   = FAN_POST;
                    fsm_load     = 1'b1;
                    fsm_load_val = TIMER_W'(FAN_TAIL);
                end
            end
            FAN_POST: begin
                fsm_dec = 1'b1;
                if (req_c != REQ_NONE) begin
                    state_next   = FAN_PRE;
                    fsm_load     = 1'b1;
                    fsm_load_val = TIMER_W'(FAN_LEAD);
                end else if (fsm_expired_c) begin
                    state_next = IDLE;
                end
            end
`ifdef AIRCON_FAULT_EN
            FAULT: begin
                state_next = FAULT;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef AIRCON_FAULT_EN
        if (fault_trip_c) begin
            state_next   = FAULT;
            fsm_load     = 1'b1;
            fsm_load_val = '0;
        end
`endif
    end

    // Relay drives follow the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            fan_q     <= 1'b0;
            heater_q  <= 1'b0;
            comp_q    <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            fan_q     <= state_next inside {FAN_PRE, HEAT, COOL, FAN_POST};
            heater_q  <= (state_next == HEAT);
            comp_q    <= (state_next == COOL);
            lockout_q <= lockout_next_c;
        end
    end

`ifdef AIRCON_FAULT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            both_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            both_q  <= bus.heating_req && bus.cooling_req;
            fault_q <= (state_next == FAULT);
        end
    end

    assign bus.fault = fault_q;
`endif

    assign bus.fan_on        = fan_q;
    assign bus.heater_on     = heater_q;
    assign bus.compressor_on = comp_q;
    assign bus.lockout       = lockout_q;

endmodule

// File: tb/tb_aircon_actuator.sv
// Scoreboard bench for aircon_actuator: directed per-cycle vectors plus relay-safety monitor.
module tb_aircon_actuator;
    import aircon_pkg::*;

`ifdef AIRCON_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] v;      // {fan, heater, compressor, lockout, fault}
        int         row;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   row_no = 0;
    exp_t sb[$];
    logic fault_seen;

    always #5 clk = ~clk;

    aircon_if bus();

    aircon_actuator #(
        .FAN_LEAD (2),
        .FAN_TAIL (3),
        .MIN_OFF  (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef AIRCON_FAULT_EN
    assign fault_seen = bus.fault;
`else
    assign fault_seen = 1'b0;
`endif

    // Drive one cycle of inputs and queue the outputs expected after the sampling edge.
    task automatic step(input bit r, input bit h, input bit c,
                        input bit f, input bit he, input bit co, input bit lo,
                        input bit fa = 1'b0);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.heating_req = h;
        bus.cooling_req = c;
        e.v   = {f, he, co, lo, fa};
        e.row = row_no;
        sb.push_back(e);
        row_no++;
    endtask

    // Scoreboard monitor: one comparison per queued vector, just after the edge.
    initial begin
        exp_t       e;
        logic [4:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                got = {bus.fan_on, bus.heater_on, bus.compressor_on, bus.lockout, fault_seen};
                n_cmp++;
                if (got !== e.v) begin
                    n_bad++;
                    $display("FAIL row%0d {fan,htr,comp,lock,fault} got=%b exp=%b t=%0t",
                             e.row, got, e.v, $time);
                end
            end
        end
    end

    // Relay safety checked on every cycle regardless of the directed vectors.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            n_cmp++;
            if ((bus.heater_on && bus.compressor_on) !== 1'b0) begin
                n_bad++;
                $display("FAIL interlock heater=%b comp=%b exp both-high=0 t=%0t",
                         bus.heater_on, bus.compressor_on, $time);
            end
            n_cmp++;
            if (((bus.heater_on || bus.compressor_on) && !bus.fan_on) !== 1'b0) begin
                n_bad++;
                $display("FAIL fan_interlock fan=%b htr=%b comp=%b exp fan=1 t=%0t",
                         bus.fan_on, bus.heater_on, bus.compressor_on, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.heating_req = 1'b0;
        bus.cooling_req = 1'b0;

        // reset state
        step(1,0,0, 0,0,0,0);
        step(1,0,0, 0,0,0,0);

        // heating: fan after 1 cycle, heater FAN_LEAD cycles later
        step(0,1,0, 1,0,0,0);
        step(0,1,0, 1,0,0,0);
        step(0,1,0, 1,1,0,0);
        step(0,1,0, 1,1,0,0);
        step(0,1,0, 1,1,0,0);
        // heating drops: heater off next edge, fan tail of 3
        step(0,0,0, 1,0,0,0);
        step(0,0,0, 1,0,0,0);
        step(0,0,0, 1,0,0,0);
        step(0,0,0, 0,0,0,0);
        step(0,0,0, 0,0,0,0);

        // cooling, then drop: lockout high for 5 cycles
        step(0,0,1, 1,0,0,0);
        step(0,0,1, 1,0,0,0);
        step(0,0,1, 1,0,1,0);
        step(0,0,1, 1,0,1,0);
        step(0,0,0, 1,0,0,1);
        step(0,0,0, 1,0,0,1);
        step(0,0,0, 1,0,0,1);
        step(0,0,0, 0,0,0,1);
        // re-request one cycle after fan falls
        step(0,0,1, 1,0,0,1);
        step(0,0,1, 1,0,0,0);
        step(0,0,1, 1,0,1,0);

        // brief cooling dropout: compressor must wait out the lockout
        step(0,0,1, 1,0,1,0);
        step(0,0,0, 1,0,0,1);
        step(0,0,1, 1,0,0,1);
        step(0,0,1, 1,0,0,1);
        step(0,0,1, 1,0,0,1);
        step(0,0,1, 1,0,0,1);
        step(0,0,1, 1,0,0,0);
        step(0,0,1, 1,0,1,0);

        // reset mid-COOL, cooling still requested afterwards
        step(1,0,1, 0,0,0,0);
        step(0,0,1, 1,0,0,0);
        step(0,0,1, 1,0,0,0);
        step(0,0,1, 1,0,1,0);

        // COOL -> HEAT switch passes through the fan tail; heater ignores lockout
        step(0,1,0, 1,0,0,1);
        step(0,1,0, 1,0,0,1);
        step(0,1,0, 1,0,0,1);
        step(0,1,0, 1,1,0,1);
        step(0,1,0, 1,1,0,1);
        step(0,1,0, 1,1,0,0);

        // re-request during FAN_POST, then drop during FAN_PRE
        step(0,0,0, 1,0,0,0);
        step(0,1,0, 1,0,0,0);
        step(0,0,0, 1,0,0,0);
        step(0,0,0, 1,0,0,0);
        step(0,0,0, 1,0,0,0);
        step(0,0,0, 0,0,0,0);

        // conflicting requests: one cycle is harmless, two trip the fault if built in
        step(0,1,1, 0,0,0,0);
        step(0,0,0, 0,0,0,0);
        step(0,1,1, 0,0,0,0);
        step(0,1,1, 0,0,0,0, FE);
        step(0,1,0, !FE,0,0,0, FE);
        step(0,1,0, !FE,0,0,0, FE);
        step(0,1,0, !FE,!FE,0,0, FE);
        step(0,1,0, !FE,!FE,0,0, FE);
        step(1,0,0, 0,0,0,0);
        step(0,0,0, 0,0,0,0);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain scoreboard left=%0d exp=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aircon_actuator.md
AIRCON_ACTUATOR -- requirements
Module: aircon_actuator

Interface
REQ-001 The block SHALL have parameter FAN_LEAD, default 2: cycles the fan runs before the heater or compressor turns on (1..255).
REQ-002 The block SHALL have parameter FAN_TAIL, default 3: cycles the fan runs after the heater or compressor turns off (1..255).
REQ-003 The block SHALL have parameter MIN_OFF, default 5: minimum compressor off-time in cycles (0..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port heating_req, input, 1 bit: heating output of the upstream aircon controller.
REQ-007 The block SHALL have port cooling_req, input, 1 bit: cooling output of the upstream aircon controller.
REQ-008 The block SHALL have port fan_on, output, 1 bit: fan relay drive.
REQ-009 The block SHALL have port heater_on, output, 1 bit: heater relay drive.
REQ-010 The block SHALL have port compressor_on, output, 1 bit: compressor relay drive.
REQ-011 The block SHALL have port lockout, output, 1 bit: high while the compressor minimum-off timer is nonzero.
REQ-012 The block SHALL have port fault, output, 1 bit: sticky fault flag; present only with AIRCON_FAULT_EN.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The effective request SHALL be HEAT if only heating_req is high, COOL if only cooling_req is high, and NONE otherwise (both high means NONE).
REQ-015 The FSM SHALL have states IDLE, FAN_PRE, HEAT, COOL, FAN_POST, plus FAULT when AIRCON_FAULT_EN is defined.
REQ-016 In IDLE with request HEAT or COOL, the FSM SHALL go to FAN_PRE, so fan_on rises 1 cycle after the request is sampled; the timer loads FAN_LEAD.
REQ-017 In FAN_PRE the timer SHALL decrement each cycle; heater_on rises exactly FAN_LEAD cycles after fan_on when the request is HEAT.
REQ-018 On FAN_PRE expiry with request COOL and lockout low, the FSM SHALL enter COOL; with lockout high it SHALL remain in FAN_PRE until lockout is low, then enter COOL on the next edge.
REQ-019 If the request becomes NONE during FAN_PRE, the FSM SHALL go to FAN_POST with the timer loaded FAN_TAIL.
REQ-020 If the request changes or drops in HEAT or COOL, the active relay SHALL fall on the next edge and the FSM SHALL enter FAN_POST with the timer loaded FAN_TAIL.
REQ-021 In FAN_POST, fan_on SHALL stay high for FAN_TAIL cycles, then the FSM returns to IDLE and fan_on falls.
REQ-022 A HEAT or COOL request during FAN_POST SHALL move the FSM to FAN_PRE with FAN_LEAD reloaded and fan_on kept high.
REQ-023 The lockout counter SHALL load MIN_OFF on the edge where compressor_on falls and decrement to 0, saturating at 0.
REQ-024 heater_on and compressor_on SHALL never be high simultaneously.
REQ-025 heater_on or compressor_on high SHALL imply fan_on high.
REQ-026 Timers SHALL be 8-bit unsigned down-counters and SHALL not wrap below 0.

Reset
REQ-027 When rst is high at an edge, the FSM SHALL go to IDLE, all timers to 0, and fan_on, heater_on, compressor_on, lockout and fault to 0.
REQ-028 rst SHALL take priority over every other event, including reset mid-HEAT or mid-COOL, where relays drop on that edge.
REQ-029 lockout SHALL be 0 after reset, so the compressor is not protected across reset.

Configuration
REQ-030 With AIRCON_FAULT_EN defined, heating_req and cooling_req both high for 2 consecutive sampled cycles SHALL force FAULT: all relays 0 and fault=1, sticky until rst.
REQ-031 Without AIRCON_FAULT_EN, the fault port and FAULT state SHALL be absent, and both-high SHALL be treated only as request NONE.

Structure
REQ-032 Package aircon_pkg SHALL hold the state typedef (act_state_t), TIMER_W=8, and the default parameter constants.
REQ-033 One sub-module, hold_timer (load, value, dec, zero flag), SHALL be instantiated twice: once for the FSM timer and once for the lockout counter.

Verification
REQ-034 Heating_req high at cycle 0 and held -> fan_on=1 at cycle 1, heater_on=1 at cycle 3, compressor_on=0 throughout.
REQ-035 Heating in steady state, heating_req drops at cycle N -> heater_on=0 at N+1, fan_on=0 at N+4, FSM in IDLE.
REQ-036 Cooling runs and then drops -> compressor_on falls, lockout=1 for 5 cycles; cooling re-requested 1 cycle after fan_on falls -> compressor_on waits until lockout=0.
REQ-037 Heating_req and cooling_req both high for 1 cycle in IDLE -> no relay activity; both high for 2 cycles with AIRCON_FAULT_EN -> fault=1, all relays 0 until rst.
REQ-038 rst asserted mid-COOL -> all outputs 0 on that edge; cooling_req still high after rst drops -> fan_on 1 cycle later, compressor_on after FAN_LEAD cycles.
REQ-039 A monitor running every cycle in every test -> heater_on and compressor_on never both high, and no relay high without fan_on.
